// File: rtl/floating_point_adder_if.sv
// Operand/result bundle for floating_point_adder.
//   in_valid  : A/B valid this cycle (master -> slave)
//   A, B      : binary32 operands (master -> slave)
//   result    : registered binary32 sum (slave -> master)
//   out_valid : result updated on the last clock edge (slave -> master)
interface floating_point_adder_if;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        out_valid;

  modport master (
    output in_valid, A, B,
    input  result, out_valid
  );

  modport slave (
    input  in_valid, A, B,
    output result, out_valid
  );
endinterface

// File: rtl/floating_point_adder.sv
// Single-precision (binary32) adder, combinational datapath with a registered result.
// Latency one clock, throughput one per clock, no back-pressure.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (result = 0, out_valid = 0)
//   bus   : floating_point_adder_if.slave (in_valid, A, B in; result, out_valid out)
//
// Configuration macro FPADD_ROUND_NEAREST_EN:
//   defined   : round to nearest, ties to even; overflow -> +/-inf
//   undefined : truncation toward zero; overflow saturates to +/-max finite
module floating_point_adder (
  input logic                   clk,
  input logic                   rst_n,
  floating_point_adder_if.slave bus
);

  localparam logic [31:0] QNan = 32'h7FC00000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              swap;
  logic [31:0]       l_op, s_op;
  logic [7:0]        l_exp, s_exp, exp_diff;
  logic [23:0]       l_man, s_man;
  logic [4:0]        shamt, lz;
  logic [50:0]       s_wide;
  logic [26:0]       s_aligned, norm_man;
  logic [27:0]       raw_sum;
  logic signed [9:0] norm_exp, fin_exp, lz_ext, lz_lim, lshift;
  logic              round_up;
  logic [24:0]       rnd_man;
  logic [23:0]       fin_man;
  logic [31:0]       arith_res, result_d, result_q;
  logic              out_valid_q;

  always_comb begin
    a_nan  = (bus.A[30:23] == 8'hFF) && (bus.A[22:0] != '0);
    b_nan  = (bus.B[30:23] == 8'hFF) && (bus.B[22:0] != '0);
    a_inf  = (bus.A[30:23] == 8'hFF) && (bus.A[22:0] == '0);
    b_inf  = (bus.B[30:23] == 8'hFF) && (bus.B[22:0] == '0);
    a_zero = (bus.A[30:0] == '0);
    b_zero = (bus.B[30:0] == '0);

    // {exp, frac} orders by magnitude, so a plain compare picks the larger operand.
    swap  = bus.B[30:0] > bus.A[30:0];
    l_op  = swap ? bus.B : bus.A;
    s_op  = swap ? bus.A : bus.B;
    l_exp = (l_op[30:23] == 8'd0) ? 8'd1 : l_op[30:23];
    s_exp = (s_op[30:23] == 8'd0) ? 8'd1 : s_op[30:23];
    l_man = {l_op[30:23] != 8'd0, l_op[22:0]};
    s_man = {s_op[30:23] != 8'd0, s_op[22:0]};

    exp_diff  = l_exp - s_exp;
    shamt     = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
    // 27 spare low bits keep every shifted-out bit visible for the sticky OR.
    s_wide    = {s_man, 27'd0} >> shamt;
    s_aligned = {s_wide[50:25], |s_wide[24:0]};

    if (l_op[31] == s_op[31]) raw_sum = {1'b0, l_man, 3'b000} + {1'b0, s_aligned};
    else                      raw_sum = {1'b0, l_man, 3'b000} - {1'b0, s_aligned};

    norm_exp = signed'({2'b00, l_exp});
    lz       = lzc27(raw_sum[26:0]);
    lz_ext   = signed'({5'd0, lz});
    lz_lim   = norm_exp - 10'sd1;
    lshift   = '0;
    if (raw_sum[27]) begin
      norm_man = {raw_sum[27:2], raw_sum[1] | raw_sum[0]};
      norm_exp = norm_exp + 10'sd1;
    end else begin
      // Left shift stops at effective exponent 1; anything left unnormalised is subnormal.
      lshift   = (lz_ext < lz_lim) ? lz_ext : lz_lim;
      norm_man = raw_sum[26:0] << lshift;
      norm_exp = norm_exp - lshift;
    end

`ifdef FPADD_ROUND_NEAREST_EN
    round_up = norm_man[2] & (norm_man[1] | norm_man[0] | norm_man[3]);
`else
    round_up = 1'b0;
`endif
    rnd_man = {1'b0, norm_man[26:3]} + {24'd0, round_up};
    if (rnd_man[24]) begin
      fin_man = rnd_man[24:1];
      fin_exp = norm_exp + 10'sd1;
    end else begin
      fin_man = rnd_man[23:0];
      fin_exp = norm_exp;
    end

    if (raw_sum == '0) begin
      arith_res = 32'h00000000;
    end else if (fin_exp >= 10'sd255) begin
`ifdef FPADD_ROUND_NEAREST_EN
      arith_res = {l_op[31], 8'hFF, 23'd0};
`else
      arith_res = {l_op[31], 8'hFE, 23'h7FFFFF};
`endif
    end else begin
      // A clear hidden bit after normalisation means exponent field 0.
      arith_res = {l_op[31], fin_man[23] ? fin_exp[7:0] : 8'd0, fin_man[22:0]};
    end

    if (a_nan || b_nan)                           result_d = QNan;
    else if (a_inf && b_inf && bus.A[31] != bus.B[31]) result_d = QNan;
    else if (a_inf)                               result_d = bus.A;
    else if (b_inf)                               result_d = bus.B;
    else if (a_zero && b_zero)                    result_d = {bus.A[31] & bus.B[31], 31'd0};
    else                                          result_d = arith_res;
  end

`ifndef FPADD_ROUND_NEAREST_EN
  logic unused_grs;
  assign unused_grs = ^norm_man[2:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= 32'h00000000;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) result_q <= result_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_floating_point_adder.sv
module tb_floating_point_adder;

  logic clk;
  logic rst_n;
  floating_point_adder_if bus ();

  floating_point_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

  task automatic test_reset();
    #3;
    n_cmp++;
    if (bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_result: got %08h want 00000000", bus.result);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [31:0] va [8], vb [8], ve [8], exp_v;
    va = '{32'h3F800000, 32'h02240000, 32'h3FC00000, 32'h80000000,
           32'h00000001, 32'h40000000, 32'h007FFFFF, 32'h00800000};
    vb = '{32'h40000000, 32'h81240000, 32'hBFC00000, 32'h80000000,
           32'h00000001, 32'hBF800000, 32'h00000001, 32'h80000001};
    ve = '{32'h40400000, 32'h01F60000, 32'h00000000, 32'h80000000,
           32'h00000002, 32'h3F800000, 32'h00800000, 32'h007FFFFF};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb_q.size() == 0) begin
          n_err++;
          $display("FAIL arith_valid[%0d]: got %b want 1", i - 1, bus.out_valid);
        end else begin
          exp_v = sb_q.pop_front();
          if (bus.result !== exp_v) begin
            n_err++;
            $display("FAIL arith[%0d]: got %08h want %08h", i - 1, bus.result, exp_v);
          end
        end
      end
      if (i < 8) begin
        bus.in_valid = 1'b1;
        bus.A        = va[i];
        bus.B        = vb[i];
        sb_q.push_back(ve[i]);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [8], vb [8], ve [8], exp_v;
    va = '{32'hFF800000, 32'h7F800000, 32'h7FFFFFFF, 32'h7F800000,
           32'h3F800000, 32'h00000000, 32'h80000000, 32'h3F800000};
    vb = '{32'hFF800000, 32'hFF800000, 32'h7FFFFFFF, 32'h3F800000,
           32'hFFC00001, 32'h80000000, 32'h00000000, 32'h00000000};
    ve = '{32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
           32'h7FC00000, 32'h00000000, 32'h00000000, 32'h3F800000};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb_q.size() == 0) begin
          n_err++;
          $display("FAIL special_valid[%0d]: got %b want 1", i - 1, bus.out_valid);
        end else begin
          exp_v = sb_q.pop_front();
          if (bus.result !== exp_v) begin
            n_err++;
            $display("FAIL special[%0d]: got %08h want %08h", i - 1, bus.result, exp_v);
          end
        end
      end
      if (i < 8) begin
        bus.in_valid = 1'b1;
        bus.A        = va[i];
        bus.B        = vb[i];
        sb_q.push_back(ve[i]);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] va [6], vb [6], ve [6], exp_v;
    va = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3F800000,
           32'h7F7FFFFF, 32'hFF7FFFFF};
    vb = '{32'h33800000, 32'h33800001, 32'h33800000, 32'hB3800001,
           32'h7F7FFFFF, 32'hFF7FFFFF};
`ifdef FPADD_ROUND_NEAREST_EN
    ve = '{32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h3F7FFFFF,
           32'h7F800000, 32'hFF800000};
`else
    ve = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3F7FFFFE,
           32'h7F7FFFFF, 32'hFF7FFFFF};
`endif
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb_q.size() == 0) begin
          n_err++;
          $display("FAIL round_valid[%0d]: got %b want 1", i - 1, bus.out_valid);
        end else begin
          exp_v = sb_q.pop_front();
          if (bus.result !== exp_v) begin
            n_err++;
            $display("FAIL round[%0d]: got %08h want %08h", i - 1, bus.result, exp_v);
          end
        end
      end
      if (i < 6) begin
        bus.in_valid = 1'b1;
        bus.A        = va[i];
        bus.B        = vb[i];
        sb_q.push_back(ve[i]);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  // Valid pattern with gaps: result must hold and out_valid must drop on idle cycles.
  task automatic test_back_to_back();
    logic [31:0] va [3], vb [3], ve [3];
    logic        pat [6];
    logic [31:0] exp_res;
    logic        exp_ov;
    int          vi;
    va  = '{32'h3F800000, 32'h40000000, 32'h40400000};
    vb  = '{32'h3F800000, 32'h40000000, 32'hBF800000};
    ve  = '{32'h40000000, 32'h40800000, 32'h40000000};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vi      = 0;
    exp_res = bus.result;
    exp_ov  = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_cmp++;
        if (bus.out_valid !== exp_ov || bus.result !== exp_res) begin
          n_err++;
          $display("FAIL b2b[%0d]: got valid=%b result=%08h want valid=%b result=%08h",
                   k - 1, bus.out_valid, bus.result, exp_ov, exp_res);
        end
      end
      if (k < 6) begin
        bus.in_valid = pat[k];
        exp_ov       = pat[k];
        if (pat[k]) begin
          bus.A   = va[vi];
          bus.B   = vb[vi];
          exp_res = ve[vi];
          vi++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 32'h3F800000;
    bus.B        = 32'h40000000;
    @(posedge clk);
    #2;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h40400000) begin
      n_err++;
      $display("FAIL pre_reset: got valid=%b result=%08h want valid=1 result=40400000",
               bus.out_valid, bus.result);
    end
    bus.A = 32'h40000000;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%b result=%08h want valid=0 result=00000000",
               bus.out_valid, bus.result);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold: got valid=%b result=%08h want valid=0 result=00000000",
               bus.out_valid, bus.result);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(32'h40800000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || sb_q.size() == 0) begin
      n_err++;
      $display("FAIL post_reset_valid: got %b want 1", bus.out_valid);
    end else if (bus.result !== sb_q[0]) begin
      n_err++;
      $display("FAIL post_reset: got %08h want %08h", bus.result, sb_q[0]);
    end
    void'(sb_q.pop_front());
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = 32'h0;
    bus.B        = 32'h0;
    test_reset();
    test_arith();
    test_specials();
    test_rounding();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
